alu_exec_unit: RTL and testbench

Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU decoder and the two operands, and returns a registered result plus branch-condition flags through a valid/ready handshake. Single-cycle ops complete in one cycle; MUL runs on an iterative shift-add engine so the stage can stall the pipeline. It sits directly downstream of the ALU decoder, between operand muxing and writeback/branch-resolve.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_mul_seq.sv | 64 ++++++
 rtl/alu_exec_unit.sv | 168 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and default width shared by the ALU decoder
// and the execute stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam int XLEN_DEF = 32;

  // 4-bit ALU control codes produced by the ALU decoder. Code 1000 doubles as
  // SUB and BEQ: the difference is the result and branch_taken is (a == b).
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_MUL  = 4'b1001,
    ALU_BNE  = 4'b1010,
    ALU_BLT  = 4'b1011,
    ALU_BGE  = 4'b1100,
    ALU_SRA  = 4'b1101,
    ALU_BLTU = 4'b1110,
    ALU_BGEU = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_HOLD     = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, low XLEN bits of a*b.
// Latency: XLEN cycles after the start edge until o_done (one multiplier bit per cycle).
// Backpressure: none; o_done is a single-cycle pulse, caller must capture o_product then.
// Ports: i_clk, i_rst (async, active high), i_start (loads operands),
//        i_a / i_b operands, o_done, o_product.
// Only compiled when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_product
);
  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            w_last;

  assign w_last    = (r_cnt == CW'(XLEN));
  assign o_done    = r_busy & w_last;
  assign o_product = r_acc;

  // Multiplicand shifts left, multiplier shifts right; bits shifted out past
  // XLEN only affect the discarded high half of the product.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (w_last) begin
        r_busy <= 1'b0;
      end else begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
      end
    end
  end

endmodule
`endif

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with registered result, zero and branch flags.
// Latency: 1 cycle for all ops; MUL takes XLEN+1 cycles when ALU_MUL_EN is defined.
// Backpressure: valid/ready; output held stable while o_out_valid & !i_out_ready,
//               i_in_ready drops while the output is stalled or a MUL is in flight.
// Ports: i_clk, i_rst (async, active high), i_in_valid/o_in_ready input handshake,
//        i_alu_control op code, i_src_a/i_src_b operands, o_out_valid/i_out_ready
//        output handshake, o_result, o_branch_taken, o_zero (o_result == 0).
// Macro ALU_MUL_EN: enables the iterative multiplier; without it code 1001
// completes in one cycle with result 0.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [3:0]      i_alu_control,
  input  logic [XLEN-1:0] i_src_a,
  input  logic [XLEN-1:0] i_src_b,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_branch_taken,
  output logic            o_zero
);
  localparam int SHW = $clog2(XLEN);

  alu_state_e      r_state;
  alu_state_e      w_state_nxt;
  logic            r_out_valid;
  logic            r_branch;
  logic [XLEN-1:0] r_result;

  alu_ctrl_e       w_op;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_drain;
  logic            w_mul_op;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_diff;
  logic            w_eq;
  logic            w_lt_s;
  logic            w_lt_u;
  logic [XLEN-1:0] w_alu_result;
  logic            w_alu_branch;

  assign w_op     = alu_ctrl_e'(i_alu_control);
  assign w_shamt  = i_src_b[SHW-1:0];
  assign w_diff   = i_src_a - i_src_b;
  assign w_eq     = (i_src_a == i_src_b);
  assign w_lt_s   = ($signed(i_src_a) < $signed(i_src_b));
  assign w_lt_u   = (i_src_a < i_src_b);
  assign w_accept = w_in_ready & i_in_valid;
  assign w_drain  = r_out_valid & i_out_ready;

`ifdef ALU_MUL_EN
  logic            w_mul_done;
  logic [XLEN-1:0] w_mul_product;

  assign w_mul_op = (w_op == ALU_MUL);

  alu_mul_seq #(.XLEN(XLEN)) u_mul (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (w_accept & w_mul_op),
    .i_a       (i_src_a),
    .i_b       (i_src_b),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );
`else
  assign w_mul_op = 1'b0;
`endif

  // Single-cycle datapath. ADD is the default arm; code 1001 lands here only
  // when the multiplier is compiled out and then yields zero.
  always_comb begin
    w_alu_result = i_src_a + i_src_b;
    w_alu_branch = 1'b0;
    case (w_op)
      ALU_SUB:  begin w_alu_result = w_diff; w_alu_branch = w_eq;    end
      ALU_AND:  w_alu_result = i_src_a & i_src_b;
      ALU_OR:   w_alu_result = i_src_a | i_src_b;
      ALU_XOR:  w_alu_result = i_src_a ^ i_src_b;
      ALU_SLL:  w_alu_result = i_src_a << w_shamt;
      ALU_SRL:  w_alu_result = i_src_a >> w_shamt;
      ALU_SRA:  w_alu_result = XLEN'($signed(i_src_a) >>> w_shamt);
      ALU_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, w_lt_s};
      ALU_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, w_lt_u};
      ALU_MUL:  w_alu_result = '0;
      ALU_BNE:  begin w_alu_result = w_diff; w_alu_branch = !w_eq;   end
      ALU_BLT:  begin w_alu_result = w_diff; w_alu_branch = w_lt_s;  end
      ALU_BGE:  begin w_alu_result = w_diff; w_alu_branch = !w_lt_s; end
      ALU_BLTU: begin w_alu_result = w_diff; w_alu_branch = w_lt_u;  end
      ALU_BGEU: begin w_alu_result = w_diff; w_alu_branch = !w_lt_u; end
      default:  ;
    endcase
  end

  // Control FSM: state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control FSM: next state and input-side ready.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = !r_out_valid || i_out_ready;
        if (w_in_ready && i_in_valid && w_mul_op) begin
          w_state_nxt = ST_MUL_BUSY;
        end
      end
`ifdef ALU_MUL_EN
      ST_MUL_BUSY: begin
        if (w_mul_done) begin
          w_state_nxt = ST_HOLD;
        end
      end
`endif
      ST_HOLD: begin
        if (w_drain) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output register. A new result may be loaded in the same cycle the old one
  // drains, which keeps out_valid high for back-to-back single-cycle ops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_result    <= '0;
      r_branch    <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept && !w_mul_op) begin
      r_result    <= w_alu_result;
      r_branch    <= w_alu_branch;
      r_out_valid <= 1'b1;
    end
`ifdef ALU_MUL_EN
    else if ((r_state == ST_MUL_BUSY) && w_mul_done) begin
      r_result    <= w_mul_product;
      r_branch    <= 1'b0;
      r_out_valid <= 1'b1;
    end
`endif
    else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_in_ready     = w_in_ready;
  assign o_out_valid    = r_out_valid;
  assign o_result       = r_result;
  assign o_branch_taken = r_branch;
  assign o_zero         = (r_result == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit (XLEN=32)
// against a behavioural model; honours ALU_MUL_EN for the multiply path.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        branch_taken;
  logic        zero;

  int checks   = 0;
  int failures = 0;

`ifdef ALU_MUL_EN
  localparam int MUL_LAT = 33;
`else
  localparam int MUL_LAT = 1;
`endif

  alu_exec_unit #(.XLEN(32)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_alu_control  (alu_control),
    .i_src_a        (src_a),
    .i_src_b        (src_b),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready),
    .o_result       (result),
    .o_branch_taken (branch_taken),
    .o_zero         (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL global_timeout observed=stuck required=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model written straight from the op-code table.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic br);
    logic [63:0] ext;
    int sh;
    sh  = int'(b[4:0]);
    ext = {{32{a[31]}}, a};
    r   = a - b;
    br  = 1'b0;
    case (op)
      4'b0000: r = a + b;
      4'b1000: br = (a == b);
      4'b0111: r = a & b;
      4'b0110: r = a | b;
      4'b0100: r = a ^ b;
      4'b0001: r = a << sh;
      4'b0101: r = a >> sh;
      4'b1101: r = ext[sh +: 32];
      4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: r = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
      4'b1001: r = a * b;
`else
      4'b1001: r = 32'd0;
`endif
      4'b1010: br = (a != b);
      4'b1011: br = ($signed(a) < $signed(b));
      4'b1100: br = ($signed(a) >= $signed(b));
      4'b1110: br = (a < b);
      default: br = (a >= b);
    endcase
  endfunction

  // Offer one op, wait for its result; reports latency from the accept edge
  // and whether in_ready was ever seen high while waiting.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic br, output logic z,
                       output int lat, output logic saw_rdy);
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    alu_control = op; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    saw_rdy = 1'b0;
    while (!out_valid && lat < 60) begin
      saw_rdy |= in_ready;
      @(posedge clk); #1;
      lat++;
    end
    res = result; br = branch_taken; z = zero;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        br;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    logic [31:0] res, exp_r;
    logic        br, z, exp_br, saw_rdy, saw_v;
    int          lat;

    rst = 1'b1; in_valid = 1'b0; alu_control = 4'd0;
    src_a = 32'd0; src_b = 32'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready",  {31'd0, in_ready},     32'd1);
    chk("rst_out_valid", {31'd0, out_valid},    32'd0);
    chk("rst_result",    result,                32'd0);
    chk("rst_zero",      {31'd0, zero},         32'd1);
    chk("rst_branch",    {31'd0, branch_taken}, 32'd0);

    // Directed vectors with hand-computed expectations.
    vecs.push_back({4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0});
    vecs.push_back({4'b1000, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1});
    vecs.push_back({4'b1101, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0});
    vecs.push_back({4'b0011, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0});
    vecs.push_back({4'b1011, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1});
    vecs.push_back({4'b1110, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0});
    vecs.push_back({4'b1100, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 1'b1});
    vecs.push_back({4'b1010, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 1'b0});
    vecs.push_back({4'b0001, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 1'b0});
    vecs.push_back({4'b0101, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 1'b0});
    vecs.push_back({4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0});
    vecs.push_back({4'b1111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0});
    vecs.push_back({4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0});
    vecs.push_back({4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0});
    vecs.push_back({4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0});
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, res, br, z, lat, saw_rdy);
      chk($sformatf("dir%0d_lat", i),    32'(lat),     32'd1);
      chk($sformatf("dir%0d_result", i), res,          vecs[i].r);
      chk($sformatf("dir%0d_branch", i), {31'd0, br},  {31'd0, vecs[i].br});
      chk($sformatf("dir%0d_zero", i),   {31'd0, z},   {31'd0, (vecs[i].r == 32'd0)});
    end

    // MUL, with an ADD offered while the unit is busy (must be ignored).
    @(posedge clk); #1;
    chk("mul_pre_ready", {31'd0, in_ready}, 32'd1);
    alu_control = 4'b1001; src_a = 32'h1234_5678; src_b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    alu_control = 4'b0000; src_a = 32'd1; src_b = 32'd1;
    lat = 1; saw_rdy = 1'b0;
    while (!out_valid && lat < 60) begin
      saw_rdy |= in_ready;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("mul_lat",        32'(lat),              32'(MUL_LAT));
`ifdef ALU_MUL_EN
    chk("mul_result",     result,                32'h369D_0368);
`else
    chk("mul_result",     result,                32'h0000_0000);
`endif
    chk("mul_branch",     {31'd0, branch_taken}, 32'd0);
    chk("mul_busy_ready", {31'd0, saw_rdy},      32'd0);
    @(posedge clk); #1;
    chk("mul_no_extra",   {31'd0, out_valid},    32'd0);

    // Output stall: result held, no new accept until the consumer drains.
    issue(4'b0000, 32'h10, 32'h20, res, br, z, lat, saw_rdy);
    chk("bp_first", res, 32'h30);
    out_ready = 1'b0;
    alu_control = 4'b1000; src_a = 32'd9; src_b = 32'd9; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", k),  {31'd0, out_valid},    32'd1);
      chk($sformatf("bp%0d_result", k), result,                32'h30);
      chk($sformatf("bp%0d_flags", k),  {30'd0, branch_taken, zero}, 32'd0);
      chk($sformatf("bp%0d_ready", k),  {31'd0, in_ready},     32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_swap_valid",  {31'd0, out_valid},    32'd1);
    chk("bp_swap_result", result,                32'd0);
    chk("bp_swap_flags",  {30'd0, branch_taken, zero}, 32'd3);
    @(posedge clk); #1;
    chk("bp_drained",     {31'd0, out_valid},    32'd0);

    // Reset while a MUL is in flight: no result may ever appear.
    issue(4'b0000, 32'd1, 32'd1, res, br, z, lat, saw_rdy);
    chk("pre_rst_result", res, 32'd2);
    @(posedge clk); #1;
    alu_control = 4'b1001; src_a = 32'd5; src_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid",  {31'd0, out_valid}, 32'd0);
    chk("midrst_result", result,             32'd0);
    chk("midrst_zero",   {31'd0, zero},      32'd1);
    chk("midrst_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk); #1 rst = 1'b0;
    saw_v = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      saw_v |= out_valid;
    end
    chk("midrst_no_result", {31'd0, saw_v},    32'd0);
    chk("midrst_idle",      {31'd0, in_ready}, 32'd1);

    // Randomized ops against the model, back to back.
    for (int i = 0; i < 150; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = pick();
      b  = pick();
      model(op, a, b, exp_r, exp_br);
      issue(op, a, b, res, br, z, lat, saw_rdy);
      chk($sformatf("rnd%0d_op%0d_lat", i, op), 32'(lat), (op == 4'b1001) ? 32'(MUL_LAT) : 32'd1);
      chk($sformatf("rnd%0d_op%0d_result", i, op), res, exp_r);
      chk($sformatf("rnd%0d_op%0d_branch", i, op), {31'd0, br}, {31'd0, exp_br});
      chk($sformatf("rnd%0d_op%0d_zero", i, op), {31'd0, z}, {31'd0, (exp_r == 32'd0)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
